// File: rtl/prtcl_chkr_block_ctrl_if.sv
// ----------------------------------------------------------------------------
// prtcl_chkr_block_ctrl_if
// Purpose : Groups the MMIO read-request handshake and the completion
//           handshake used by prtcl_chkr_block_ctrl.
// Signals :
//   i_mmio_rd_valid  - read request valid            (requester -> block)
//   i_mmio_rd_tag    - read request tag, TAG_W bits  (requester -> block)
//   o_mmio_rd_ready  - read request accepted         (block -> requester)
//   o_cpl_valid      - blocked-read completion valid (block -> consumer)
//   o_cpl_tag        - completion tag, TAG_W bits    (block -> consumer)
//   o_cpl_data       - completion data, 64 bits      (block -> consumer)
//   i_cpl_ready      - completion consumer ready     (consumer -> block)
// Modports: master = requester/consumer side, slave = the block itself.
// ----------------------------------------------------------------------------
interface prtcl_chkr_block_ctrl_if #(
  parameter int TAG_W = 10
) ();

  logic             i_mmio_rd_valid;
  logic [TAG_W-1:0] i_mmio_rd_tag;
  logic             o_mmio_rd_ready;
  logic             o_cpl_valid;
  logic [TAG_W-1:0] o_cpl_tag;
  logic [63:0]      o_cpl_data;
  logic             i_cpl_ready;

  modport master (
    output i_mmio_rd_valid,
    output i_mmio_rd_tag,
    input  o_mmio_rd_ready,
    input  o_cpl_valid,
    input  o_cpl_tag,
    input  o_cpl_data,
    output i_cpl_ready
  );

  modport slave (
    input  i_mmio_rd_valid,
    input  i_mmio_rd_tag,
    output o_mmio_rd_ready,
    output o_cpl_valid,
    output o_cpl_tag,
    output o_cpl_data,
    input  i_cpl_ready
  );

endinterface

// File: rtl/prtcl_chkr_block_ctrl.sv
// ----------------------------------------------------------------------------
// prtcl_chkr_block_ctrl
// Purpose : Watches a protocol-checker error vector. The first unmasked error
//           moves the block from IDLE to BLOCK, where MMIO reads are accepted
//           into a pending FIFO and answered with all-ones completions. A CSR
//           clear request (in BLOCK) drains the pending completions, then
//           enters CLEAR, pulses o_clear_errors for CLR_CYCLES cycles and
//           returns to IDLE with the captured error state wiped.
// Ports   :
//   clk, rst            - clock, synchronous active-high reset
//   i_error_vector      - per-cycle error pulses (ERR_W)
//   i_err_mask          - 1 = ignore that error bit (ERR_W)
//   i_clear_req         - single-cycle clear request
//   mmio                - read request / completion handshakes (slave)
//   o_blocking_traffic  - high in BLOCK and CLEAR
//   o_first_err         - masked vector that caused entry to BLOCK
//   o_err_count         - saturating count of error cycles (16 bits)
//   o_clear_errors      - clear pulse to the checker
//   o_clear_busy        - clear pending or in progress
//   o_state             - IDLE = 0, BLOCK = 1, CLEAR = 2
// ----------------------------------------------------------------------------
module prtcl_chkr_block_ctrl #(
  parameter int ERR_W      = 16,
  parameter int TAG_W      = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int CLR_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ERR_W-1:0]     i_error_vector,
  input  logic [ERR_W-1:0]     i_err_mask,
  input  logic                 i_clear_req,
  prtcl_chkr_block_ctrl_if.slave mmio,
  output logic                 o_blocking_traffic,
  output logic [ERR_W-1:0]     o_first_err,
  output logic [15:0]          o_err_count,
  output logic                 o_clear_errors,
  output logic                 o_clear_busy,
  output logic [1:0]           o_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(CLR_CYCLES + 1);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLOCK = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ERR_W-1:0] firstErr_q, firstErr_d;
  logic [15:0]      errCount_q, errCount_d;
  logic             clearPending_q, clearPending_d;
  logic [CNT_W-1:0] clrCnt_q, clrCnt_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   fifoCount_q, fifoCount_d;
  logic [TAG_W-1:0] fifoMem_q [FIFO_DEPTH];

  logic [ERR_W-1:0] maskedErr;
  logic             errHit;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             push;
  logic             pop;

  assign maskedErr = i_error_vector & ~i_err_mask;
  assign errHit    = |maskedErr;
  assign fifoFull  = (fifoCount_q == FIFO_FULL);
  assign fifoEmpty = (fifoCount_q == '0);

  // Reads are only taken while blocking; fullness alone gates the push, so a
  // pop in the same cycle never frees a slot early.
  assign push = (state_q == BLOCK) & mmio.i_mmio_rd_valid & ~fifoFull;
  assign pop  = ~fifoEmpty & mmio.i_cpl_ready;

  // Next-state and datapath update. Everything holds by default; the FSM case
  // then overrides what each state is allowed to change.
  always_comb begin
    state_d        = state_q;
    firstErr_d     = firstErr_q;
    errCount_d     = errCount_q;
    clearPending_d = clearPending_q;
    clrCnt_d       = clrCnt_q;
    wrPtr_d        = wrPtr_q;
    rdPtr_d        = rdPtr_q;
    fifoCount_d    = fifoCount_q;

    if ((state_q != CLEAR) && errHit && (errCount_q != 16'hFFFF)) begin
      errCount_d = errCount_q + 16'd1;
    end

    if (push) begin
      wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   fifoCount_d = fifoCount_q + 1'b1;
      2'b01:   fifoCount_d = fifoCount_q - 1'b1;
      default: fifoCount_d = fifoCount_q;
    endcase

    case (state_q)
      IDLE: begin
        if (errHit) begin
          state_d    = BLOCK;
          firstErr_d = maskedErr;
        end
      end
      BLOCK: begin
        if (i_clear_req) begin
          clearPending_d = 1'b1;
        end
        // Pending completions are drained before the clear starts, and a read
        // arriving in the same cycle keeps us here to answer it too.
        if (clearPending_q && fifoEmpty && !push) begin
          state_d  = CLEAR;
          clrCnt_d = '0;
        end
      end
      CLEAR: begin
        if (clrCnt_q == CLR_LAST) begin
          state_d        = IDLE;
          firstErr_d     = '0;
          errCount_d     = '0;
          clearPending_d = 1'b0;
        end else begin
          clrCnt_d = clrCnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset also empties the FIFO by
  // zeroing its pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      firstErr_q     <= '0;
      errCount_q     <= '0;
      clearPending_q <= 1'b0;
      clrCnt_q       <= '0;
      wrPtr_q        <= '0;
      rdPtr_q        <= '0;
      fifoCount_q    <= '0;
    end else begin
      state_q        <= state_d;
      firstErr_q     <= firstErr_d;
      errCount_q     <= errCount_d;
      clearPending_q <= clearPending_d;
      clrCnt_q       <= clrCnt_d;
      wrPtr_q        <= wrPtr_d;
      rdPtr_q        <= rdPtr_d;
      fifoCount_q    <= fifoCount_d;
    end
  end

  // Tag storage needs no reset: an entry is only visible once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= mmio.i_mmio_rd_tag;
    end
  end

  // Completion tag and data are forced to zero when nothing is pending so
  // that every output reads 0 straight out of reset.
  assign mmio.o_mmio_rd_ready = (state_q == BLOCK) & ~fifoFull;
  assign mmio.o_cpl_valid     = ~fifoEmpty;
  assign mmio.o_cpl_tag       = fifoEmpty ? '0 : fifoMem_q[rdPtr_q];
  assign mmio.o_cpl_data      = fifoEmpty ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;

  assign o_blocking_traffic = (state_q == BLOCK) | (state_q == CLEAR);
  assign o_first_err        = firstErr_q;
  assign o_err_count        = errCount_q;
  assign o_clear_errors     = (state_q == CLEAR);
  assign o_clear_busy       = clearPending_q | (state_q == CLEAR);
  assign o_state            = state_q;

endmodule

// File: doc/prtcl_chkr_block_ctrl.md
PRTCL_CHKR_BLOCK_CTRL -- requirements
Module: prtcl_chkr_block_ctrl

Interface
REQ-001 Parameter ERR_W, default 16; width of the protocol-checker error vector.
REQ-002 Parameter TAG_W, default 10; width of the MMIO read tag.
REQ-003 Parameter FIFO_DEPTH, default 8, power of 2; depth of the pending-read FIFO.
REQ-004 Parameter CLR_CYCLES, default 4, minimum 1; length of the clear pulse in cycles.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1; the single clock.
REQ-007 Port rst, input, 1; synchronous active-high reset.
REQ-008 Port i_error_vector, input, ERR_W; per-cycle error pulses.
REQ-009 Port i_err_mask, input, ERR_W; CSR mask, 1 = ignore that bit.
REQ-010 Port i_clear_req, input, 1; single-cycle CSR clear request.
REQ-011 Port i_mmio_rd_valid / i_mmio_rd_tag, input, 1 / TAG_W; MMIO read request.
REQ-012 Port o_mmio_rd_ready, output, 1; read accepted when valid & ready.
REQ-013 Port o_cpl_valid / o_cpl_tag / o_cpl_data, output, 1 / TAG_W / 64; blocked-read completion.
REQ-014 Port i_cpl_ready, input, 1; completion consumer ready.
REQ-015 Port o_blocking_traffic, output, 1; high in BLOCK and CLEAR.
REQ-016 Port o_first_err, output, ERR_W; masked vector that caused entry to BLOCK.
REQ-017 Port o_err_count, output, 16; count of error cycles, saturating.
REQ-018 Port o_clear_errors, output, 1; clear pulse to the checker.
REQ-019 Port o_clear_busy, output, 1; high while a clear is pending or in progress.
REQ-020 Port o_state, output, 2; IDLE = 0, BLOCK = 1, CLEAR = 2.

Function
REQ-021 err_hit SHALL equal the OR of (i_error_vector & ~i_err_mask), evaluated every cycle.
REQ-022 In IDLE, err_hit SHALL move the FSM to BLOCK on the next edge.
- The same edge registers o_first_err with the masked vector.
- o_blocking_traffic SHALL be high from the following cycle.
REQ-023 In BLOCK, err_hit SHALL NOT modify o_first_err.
REQ-024 In IDLE and BLOCK, o_err_count SHALL increment by 1 on each err_hit cycle.
- It SHALL saturate at 0xFFFF.
- In CLEAR, err_hit SHALL be ignored: no count and no state change.
REQ-025 o_mmio_rd_ready SHALL equal (state == BLOCK) & ~fifo_full.
- i_mmio_rd_valid SHALL be ignored in IDLE and CLEAR.
REQ-026 An accepted read SHALL push its tag into the FIFO.
- The earliest o_cpl_valid for that tag is the next cycle.
REQ-027 o_cpl_valid SHALL equal ~fifo_empty, with o_cpl_tag set to the FIFO head.
- o_cpl_data SHALL be 64'hFFFF_FFFF_FFFF_FFFF.
- The FIFO SHALL pop when o_cpl_valid & i_cpl_ready.
REQ-028 FIFO ordering SHALL be strict FIFO, and read and write pointers SHALL wrap modulo FIFO_DEPTH.
- When full, no push is accepted, even if a pop occurs in the same cycle.
- When not full, push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-029 In BLOCK, i_clear_req SHALL set clear_pending.
- Repeated requests have no further effect.
- i_clear_req SHALL be ignored in IDLE and CLEAR.
REQ-030 BLOCK SHALL transition to CLEAR on the first edge where clear_pending is set, the FIFO is empty and no push occurs in that cycle.
- Completions of already-pending reads are always drained first.
REQ-031 In CLEAR, o_clear_errors SHALL be high for exactly CLR_CYCLES consecutive cycles.
- The FSM then SHALL return to IDLE.
- On that return edge, o_first_err, o_err_count and clear_pending SHALL be cleared to 0.
REQ-032 o_clear_busy SHALL equal clear_pending | (state == CLEAR).
REQ-033 In the first IDLE cycle after CLEAR, an err_hit SHALL immediately re-enter BLOCK per REQ-022.

Reset
REQ-034 When rst is high at an edge, the block SHALL enter IDLE and empty the FIFO.
- o_first_err = 0, o_err_count = 0, clear_pending = 0.
- All outputs = 0, including o_cpl_valid, o_mmio_rd_ready, o_blocking_traffic, o_clear_errors, o_clear_busy and o_state.
REQ-035 Reset SHALL take effect from any state.
- Reset mid-CLEAR SHALL truncate the o_clear_errors pulse.
- Pending FIFO entries SHALL be discarded without completion.

Verification
REQ-036 Masked error: i_err_mask = 16'h0002, i_error_vector = 16'h0002 for 1 cycle -> state stays IDLE, o_err_count = 0.
REQ-037 Error entry: i_error_vector = 16'h0810 for 1 cycle, then 16'h0001 for 1 cycle.
- o_first_err = 16'h0810, o_err_count = 2.
- o_blocking_traffic is high 1 cycle after the first error.
REQ-038 Blocked reads, part 1: in BLOCK, 9 back-to-back reads with tags 1..9 and i_cpl_ready = 0.
- Tags 1..8 are accepted; o_mmio_rd_ready = 0 on the 9th.
REQ-039 Blocked reads, part 2: then raise i_cpl_ready.
- Completions come out as tags 1..8 in order, all with data 64'hFFFF_FFFF_FFFF_FFFF.
REQ-040 Clear with 3 pending completions: i_clear_req is pulsed.
- o_clear_busy goes high.
- CLEAR is entered only after the 3rd pop; o_clear_errors is high for 4 cycles.
- State returns to IDLE with o_first_err = 0 and o_err_count = 0.
REQ-041 Reset mid-CLEAR: rst asserted in the 2nd CLEAR cycle -> next cycle all outputs 0 and state IDLE.
REQ-042 Saturation: 70000 consecutive err_hit cycles in BLOCK -> o_err_count = 16'hFFFF with no wrap.
